// File: rtl/game_pkg.sv
// Shared definitions for the snake-game controller: one-hot status encoding
// and default timing constants for a 50 MHz board clock.
package game_pkg;

   localparam int unsigned STATUS_W = 5;

   typedef enum logic [STATUS_W-1:0] {
      ST_START = 5'b00001,
      ST_PLAY  = 5'b00010,
      ST_PAUSE = 5'b00100,
      ST_DIE   = 5'b01000,
      ST_END   = 5'b10000
   } state_t;

   localparam int unsigned CLK_HZ             = 50_000_000;
   localparam int unsigned DEF_LIVES          = 3;
   localparam int unsigned DEF_DEB_CYCLES     = CLK_HZ / 50;   // 20 ms
   localparam int unsigned DEF_FLASH_HALF     = CLK_HZ / 4;    // 250 ms
   localparam int unsigned DEF_RESPAWN_CYCLES = CLK_HZ;        // 1 s
   localparam int unsigned DEF_HOLDOFF_CYCLES = CLK_HZ;        // 1 s

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Board-side bundle of the game controller: raw keys and collisions in,
// status, blink, lives and event pulses out.
interface game_ctrl_fsm_if #(
   parameter int unsigned LW = 2
);
   import game_pkg::*;

   logic                Key_left;
   logic                Key_right;
   logic                Key_up;
   logic                Key_down;
   logic                Key_pause;
   logic                Hit_wall_sig;
   logic                Hit_body_sig;
   logic [STATUS_W-1:0] Game_status;
   logic                Flash_sig;
   logic [LW-1:0]       Lives;
   logic                Respawn_pulse;
   logic                Game_over_pulse;

   // Controller side.
   modport master (
      input  Key_left, Key_right, Key_up, Key_down, Key_pause,
      input  Hit_wall_sig, Hit_body_sig,
      output Game_status, Flash_sig, Lives, Respawn_pulse, Game_over_pulse
   );

   // Keys / collision logic / display side.
   modport slave (
      output Key_left, Key_right, Key_up, Key_down, Key_pause,
      output Hit_wall_sig, Hit_body_sig,
      input  Game_status, Flash_sig, Lives, Respawn_pulse, Game_over_pulse
   );

endinterface

// File: rtl/game_ctrl_fsm_key_debounce.sv
// Per-key 2-FF synchroniser plus debounce counter; emits a one-cycle press
// when the accepted level rises.
module key_debounce
   import game_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic Clk_50mhz,
   input  logic Rst,
   input  logic key_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = max_u(1, $clog2(DEB_CYCLES));

   logic          r_sync0;
   logic          r_sync1;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge Clk_50mhz or posedge Rst) begin
      if (Rst) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
         r_cnt   <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
      end else begin
         r_sync0 <= key_raw;
         r_sync1 <= r_sync0;
         press   <= 1'b0;
         if (r_sync1 == level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            level <= r_sync1;
            r_cnt <= '0;
            press <= r_sync1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Snake-game controller: debounced keys, pause, lives with timed respawn,
// blinking display enable and an end-screen hold-off.
module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int unsigned LIVES          = DEF_LIVES,
   parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
   parameter int unsigned FLASH_HALF     = DEF_FLASH_HALF,
   parameter int unsigned RESPAWN_CYCLES = DEF_RESPAWN_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int unsigned LW             = $clog2(LIVES + 1)
) (
   input  logic            Clk_50mhz,
   input  logic            Rst,
   game_ctrl_fsm_if.master bus
);

   // DIE and END never overlap, so one timer serves both.
   localparam int unsigned TMAX = max_u(RESPAWN_CYCLES, HOLDOFF_CYCLES);
   localparam int unsigned TW   = max_u(1, $clog2(TMAX));
   localparam int unsigned FW   = max_u(1, $clog2(FLASH_HALF));

   logic [4:0] w_press;
   logic [4:0] w_unused_level;
   logic       w_dir_press;
   logic       w_pause_press;
   logic       w_hit;
   logic       w_flash_wrap;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [FW-1:0] r_fcnt;
   logic          r_flash;
   logic [LW-1:0] r_lives;
   logic          r_respawn;
   logic          r_gameover;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
      .Clk_50mhz(Clk_50mhz), .Rst(Rst), .key_raw(bus.Key_left),
      .level(w_unused_level[0]), .press(w_press[0])
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
      .Clk_50mhz(Clk_50mhz), .Rst(Rst), .key_raw(bus.Key_right),
      .level(w_unused_level[1]), .press(w_press[1])
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .Clk_50mhz(Clk_50mhz), .Rst(Rst), .key_raw(bus.Key_up),
      .level(w_unused_level[2]), .press(w_press[2])
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
      .Clk_50mhz(Clk_50mhz), .Rst(Rst), .key_raw(bus.Key_down),
      .level(w_unused_level[3]), .press(w_press[3])
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
      .Clk_50mhz(Clk_50mhz), .Rst(Rst), .key_raw(bus.Key_pause),
      .level(w_unused_level[4]), .press(w_press[4])
   );

   assign w_dir_press   = |w_press[3:0];
   assign w_pause_press = w_press[4];
   assign w_hit         = bus.Hit_wall_sig | bus.Hit_body_sig;
   assign w_flash_wrap  = (r_fcnt == FW'(FLASH_HALF - 1));

   always_ff @(posedge Clk_50mhz or posedge Rst) begin
      if (Rst) begin
         r_state    <= ST_START;
         r_timer    <= '0;
         r_fcnt     <= '0;
         r_flash    <= 1'b1;
         r_lives    <= LW'(LIVES);
         r_respawn  <= 1'b0;
         r_gameover <= 1'b0;
      end else begin
         // Defaults give the state-entry clears; DIE/END arms override them.
         r_timer    <= '0;
         r_fcnt     <= '0;
         r_flash    <= 1'b1;
         r_respawn  <= 1'b0;
         r_gameover <= 1'b0;
         case (r_state)
            ST_START: begin
               if (w_dir_press) begin
                  r_state <= ST_PLAY;
                  r_lives <= LW'(LIVES);
               end
            end
            ST_PLAY: begin
               if (w_hit) begin
                  if (r_lives > LW'(1)) begin
                     r_state <= ST_DIE;
                     r_lives <= r_lives - LW'(1);
                  end else begin
                     r_state    <= ST_END;
                     r_lives    <= '0;
                     r_gameover <= 1'b1;
                  end
               end else if (w_pause_press) begin
                  r_state <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (w_pause_press) begin
                  r_state <= ST_PLAY;
               end
            end
            ST_DIE: begin
               r_fcnt  <= w_flash_wrap ? '0 : r_fcnt + FW'(1);
               r_flash <= w_flash_wrap ? ~r_flash : r_flash;
               r_timer <= r_timer + TW'(1);
               if (r_timer == TW'(RESPAWN_CYCLES - 1)) begin
                  r_state   <= ST_PLAY;
                  r_respawn <= 1'b1;
                  r_timer   <= '0;
                  r_fcnt    <= '0;
                  r_flash   <= 1'b1;
               end
            end
            ST_END: begin
               r_fcnt  <= w_flash_wrap ? '0 : r_fcnt + FW'(1);
               r_flash <= w_flash_wrap ? ~r_flash : r_flash;
               if (r_timer == TW'(HOLDOFF_CYCLES - 1)) begin
                  r_timer <= r_timer;
                  if (w_dir_press) begin
                     r_state <= ST_START;
                     r_lives <= LW'(LIVES);
                     r_timer <= '0;
                     r_fcnt  <= '0;
                     r_flash <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= ST_START;
               r_lives <= LW'(LIVES);
            end
         endcase
      end
   end

   assign bus.Game_status     = r_state;
   assign bus.Flash_sig       = r_flash;
   assign bus.Lives           = r_lives;
   assign bus.Respawn_pulse   = r_respawn;
   assign bus.Game_over_pulse = r_gameover;

endmodule
